// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS datapath: shift-add multiply,
// restoring divide, one bit per cycle, with a final sign-fix cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MTHI = 6'd17;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_MTLO = 6'd19;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic                 done_q, done_d;

  logic                 start;
  logic                 is_signed;
  logic                 sa, sb;
  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  // func 24..27 share the pattern 0110xx; bit 0 selects unsigned, bit 1 selects divide
  assign start     = op_valid && (func[5:2] == 4'b0110);
  assign is_signed = ~func[0];
  assign sa        = is_signed & rs_data[WIDTH-1];
  assign sb        = is_signed & rt_data[WIDTH-1];
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)     state_d = CALC;
      CALC: if (last_iter) state_d = FIX;
      FIX:                 state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    stall   = busy && op_valid && ((func == F_MFHI) || (func == F_MFLO));
    mf_data = (func == F_MFHI) ? hi_q : lo_q;
    done    = done_q;
    hi      = hi_q;
    lo      = lo_q;
  end

  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    trial     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = {1'b0, trial} - {2'b00, b_q};
    prod      = neg_q ? -acc_q : acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // both ops keep rs magnitude in the low half and rt magnitude in b_q
          acc_d     = {{WIDTH{1'b0}}, (sa ? -rs_data : rs_data)};
          b_d       = sb ? -rt_data : rt_data;
          is_div_d  = func[1];
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          div0_d    = (rt_data == '0);
          cnt_d     = '0;
        end else if (op_valid && (func == F_MTHI)) begin
          hi_d = rs_data;
        end else if (op_valid && (func == F_MTLO)) begin
          lo_d = rs_data;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!is_div_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = div0_q ? '1 : (neg_q ? -quo : quo);
          hi_d = neg_rem_q ? -rem : rem;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [5:0]   func = '0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         busy, done, stall;
  logic [W-1:0] mf_data, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .func(func),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
    .stall(stall), .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", {32'h0, hi}, {32'h0, mon_e[2*W-1:W]});
        check("result_lo", {32'h0, lo}, {32'h0, mon_e[W-1:0]});
        check("busy_in_done_cycle", {63'h0, busy}, 64'h0);
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    op_valid = 1'b1;
    func     = f;
    rs_data  = a;
    rt_data  = b;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    rs_data  = $urandom;
    rt_data  = $urandom;
  endtask

  task automatic wait_done(input string name);
    int j;
    int bad_busy;
    bit found;
    found = 0;
    bad_busy = 0;
    for (j = 0; j < 40; j++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done in 40 cycles expected done after %0d", name, W + 1);
    end else begin
      check({name, "_latency"}, 64'(j), 64'(W + 1));
      check({name, "_busy_held"}, 64'(bad_busy), 64'h0);
      @(negedge clock);
      check({name, "_done_pulse"}, {63'h0, done}, 64'h0);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_q.push_back({eh, el});
    issue(f, a, b);
    wait_done(name);
  endtask

  task automatic expect_no_done(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) cnt++;
    end
    check(name, 64'(cnt), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    bit found;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hi", {32'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);

    run_op("mult_neg",   6'd24, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",  6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg",    6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",       6'd27, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_zero",  6'd27, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op("div_ovf",    6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    run_op("div_zero_s", 6'd26, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);

    // MULT in flight: MTLO must be ignored, MFHI must stall until done
    exp_q.push_back({32'h3, 32'h0});
    issue(6'd24, 32'h00010000, 32'h00030000);
    @(negedge clock);
    op_valid = 1'b1;
    func     = 6'd19;
    rs_data  = 32'h1234;
    check("no_stall_on_mtlo", {63'h0, stall}, 64'h0);
    @(posedge clock);
    #1;
    func = 6'd16;
    bad = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        found = 1;
        check("stall_after_done", {63'h0, stall}, 64'h0);
        check("mfhi_after_done", {32'h0, mf_data}, 64'h3);
        break;
      end
      if (stall !== 1'b1) bad++;
    end
    check("stall_while_busy", 64'(bad), 64'h0);
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL stall_op_timeout: got no done expected done");
    end
    op_valid = 1'b0;
    func = 6'd18;
    @(negedge clock);
    check("mflo_idle", {32'h0, mf_data}, 64'h0);

    // MTHI in IDLE is single-cycle
    op_valid = 1'b1;
    func     = 6'd17;
    rs_data  = 32'hABCD;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    check("mthi_no_busy", {63'h0, busy}, 64'h0);
    @(negedge clock);
    check("mthi_hi", {32'h0, hi}, 64'hABCD);
    check("mthi_lo_kept", {32'h0, lo}, 64'h0);

    // Reset in the middle of a DIV aborts without writing a result
    issue(6'd26, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    expect_no_done("abort_no_result");

    // Reset wins over a simultaneous start
    @(negedge clock);
    reset_n  = 1'b0;
    op_valid = 1'b1;
    func     = 6'd24;
    rs_data  = 32'd9;
    rt_data  = 32'd9;
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    op_valid = 1'b0;
    @(negedge clock);
    check("reset_beats_start", {63'h0, busy}, 64'h0);
    expect_no_done("reset_start_no_result");

    run_op("mult_after_reset", 6'd24, 32'd6, 32'd7, 32'd0, 32'd42);

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit sitting beside the ALU in the MIPS datapath.
- Consumes register-file read data (rs, rt) and the R-format func field for the MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO instructions.
- Holds the architectural HI/LO registers and supplies MFHI/MFLO data to the MemtoReg path.
- Multi-cycle operations raise busy; the control path stalls the PC when a move-from (MFHI/MFLO) hits while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock shared with Register_File/DataMemory
- reset_n  input  1  synchronous, active-low reset
- op_valid  input  1  func is a valid R-format mult/div/move instruction this cycle
- func  input  6  IR[5:0]; 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO
- rs_data  input  WIDTH  ReadData1 (multiplicand / dividend / MT source)
- rt_data  input  WIDTH  ReadData2 (multiplier / divisor)
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV
- stall  output  1  combinational: busy & op_valid & (func==16 | func==18)
- mf_data  output  WIDTH  combinational: HI when func==16, otherwise LO
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

Behaviour:
- Clock and reset
  - Single clock domain.
  - Reset is sampled at the posedge while reset_n==0.
  - Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal working registers 0.
- FSM states: IDLE, CALC, FIX.
- IDLE
  - An accepted MULT/MULTU/DIV/DIVU (op_valid & func in 24..27) captures operands and the op type, latches the operand signs, converts signed operands to magnitudes (signed ops only), clears the counter and goes to CALC.
  - MTHI writes hi<=rs_data at this edge; MTLO writes lo<=rs_data at this edge. Single cycle, no busy.
  - Any other func, or op_valid=0: no effect.
- CALC: one iteration per cycle, WIDTH iterations; on counter==WIDTH-1 go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator, LSB-first.
  - Divide: restoring divide, one quotient bit per cycle, MSB-first.
- FIX: applies sign correction, writes hi/lo, returns to IDLE.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Result mapping
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
  - Divisor==0 (signed or unsigned): lo = all ones, hi = original rs_data. No exception. Still full latency.
  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0. Wrap, no trap.
- Latency and signal timing (start accepted at edge k)
  - busy=1 from after edge k through edge k+WIDTH+1.
  - hi/lo are updated at edge k+WIDTH+1.
  - done=1 for exactly the cycle following edge k+WIDTH+1, with busy=0 in that same cycle.
  - Total: WIDTH+1 edges from accept to result.
  - hi/lo keep their old values for the whole operation and change only in FIX.
- Back-to-back: a new start may be accepted in the done cycle, since the FSM is in IDLE.
- While busy
  - MULT/DIV/MTHI/MTLO requests are ignored (no queueing, no effect on the running op).
  - MFHI/MFLO assert stall; mf_data then shows stale values and the consumer must hold.
- Operand capture: rs_data/rt_data are used only at the accept edge; later changes have no effect.
- Reset mid-operation: aborts to IDLE; hi=lo=0; busy and done deassert the next cycle; no partial result written.
- Simultaneous reset and start: reset wins.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5 -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; latency exactly WIDTH+1 edges.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, rs=100, rt=7 -> lo=14, hi=2.
- DIVU, rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100, done after 33 cycles. DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a MULT: issue MTLO rs=0x1234 -> ignored. Issue MFHI -> stall=1 until done, after which mf_data = new hi. MTHI rs=0xABCD in IDLE -> hi=0xABCD next cycle, busy stays 0.
- reset_n=0 at iteration 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; a fresh MULT 6*7 then gives lo=42, hi=0.
